blockfifo_reader: RTL and testbench

- Read-side controller for the block FIFO.
- Waits for the FIFO to report full, then walks the FIFO's read pointer from 0 to len-1 and streams each word out on a valid/ready interface with an end-of-block marker.
- After the last word is accepted, it pulses the FIFO clear so the writer can refill the block.
- Sits between the block FIFO and the downstream pixel/line consumer.

---
 rtl/blockfifo_reader.sv | 146 ++++++++++++++
 tb/tb_blockfifo_reader.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/blockfifo_reader.sv
// Block FIFO read controller: waits for a full block, streams len words (first word 2 cycles after full), then pulses fifo_clear.
// Output holds while out_valid & !out_ready; BLOCKFIFO_READER_DOUBLE_EN streams each block twice before clearing.
module blockfifo_reader #(
  parameter int len     = 320,
  parameter int wid     = 8,
  parameter int addrWid = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fifo_ready,
  input  logic [wid-1:0]     fifo_data,
  output logic [addrWid-1:0] read_ptr,
  output logic               fifo_clear,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [wid-1:0]     out_data,
  output logic               out_last,
  output logic               busy
);

  localparam logic [addrWid-1:0] PTR_END  = addrWid'(len);
  localparam logic [addrWid-1:0] PTR_LAST = addrWid'(len - 1);
  localparam logic [addrWid-1:0] PTR_ONE  = addrWid'(1);
  localparam logic               ONE_WORD = (len == 1);

  typedef enum logic [1:0] {IDLE, LOAD, STREAM, CLEAR} state_t;

  state_t             state, state_nxt;
  logic [addrWid-1:0] ptr_nxt;
  logic [wid-1:0]     data_nxt;
  logic               valid_nxt;
  logic               last_nxt;
  logic               accept;

  assign accept = out_valid & out_ready;

`ifdef BLOCKFIFO_READER_DOUBLE_EN
  // read_ptr sits at len when pass 1 ends, so word 0 is replayed from this copy
  logic           pass, pass_nxt;
  logic [wid-1:0] word0, word0_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      pass  <= 1'b0;
      word0 <= '0;
    end else begin
      pass  <= pass_nxt;
      word0 <= word0_nxt;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      read_ptr  <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      read_ptr  <= ptr_nxt;
      out_data  <= data_nxt;
      out_valid <= valid_nxt;
      out_last  <= last_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    ptr_nxt    = read_ptr;
    data_nxt   = out_data;
    valid_nxt  = out_valid;
    last_nxt   = out_last;
    fifo_clear = 1'b0;
    busy       = (state != IDLE);
`ifdef BLOCKFIFO_READER_DOUBLE_EN
    pass_nxt   = pass;
    word0_nxt  = word0;
`endif
    case (state)
      IDLE: begin
        ptr_nxt   = '0;
        valid_nxt = 1'b0;
        last_nxt  = 1'b0;
`ifdef BLOCKFIFO_READER_DOUBLE_EN
        pass_nxt  = 1'b0;
`endif
        if (!fifo_ready) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        data_nxt  = fifo_data;
        valid_nxt = 1'b1;
        last_nxt  = ONE_WORD;
        ptr_nxt   = PTR_ONE;
`ifdef BLOCKFIFO_READER_DOUBLE_EN
        word0_nxt = fifo_data;
`endif
        state_nxt = STREAM;
      end
      STREAM: begin
        if (accept) begin
          if (read_ptr != PTR_END) begin
            data_nxt = fifo_data;
            last_nxt = (read_ptr == PTR_LAST);
            ptr_nxt  = read_ptr + PTR_ONE;
          end else begin
`ifdef BLOCKFIFO_READER_DOUBLE_EN
            if (!pass) begin
              pass_nxt = 1'b1;
              data_nxt = word0;
              last_nxt = ONE_WORD;
              ptr_nxt  = PTR_ONE;
            end else begin
              valid_nxt = 1'b0;
              last_nxt  = 1'b0;
              state_nxt = CLEAR;
            end
`else
            valid_nxt = 1'b0;
            last_nxt  = 1'b0;
            state_nxt = CLEAR;
`endif
          end
        end
      end
      CLEAR: begin
        fifo_clear = 1'b1;
        ptr_nxt    = '0;
        state_nxt  = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_blockfifo_reader.sv
// Scoreboard bench: a len=4 instance for directed cases and a default len=320 instance for full blocks.
module tb_blockfifo_reader;

`ifdef BLOCKFIFO_READER_DOUBLE_EN
  localparam int NPASS = 2;
`else
  localparam int NPASS = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // len=4 instance and its FIFO model
  logic       a_fill, a_full, a_fifo_ready, a_fifo_clear, a_out_valid, a_out_ready, a_out_last, a_busy;
  logic [7:0] a_fifo_data, a_out_data;
  logic [8:0] a_read_ptr;
  logic [7:0] a_mem [4];

  assign a_fifo_ready = ~a_full;
  assign a_fifo_data  = (a_read_ptr < 9'd4) ? a_mem[a_read_ptr[1:0]] : 8'h00;
  always @(posedge clk) begin
    if (rst || a_fifo_clear) a_full <= 1'b0;
    else if (a_fill)         a_full <= 1'b1;
  end

  blockfifo_reader #(.len(4), .wid(8), .addrWid(9)) u_a (
    .clk(clk), .reset(rst), .fifo_ready(a_fifo_ready), .fifo_data(a_fifo_data),
    .read_ptr(a_read_ptr), .fifo_clear(a_fifo_clear), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_data(a_out_data), .out_last(a_out_last), .busy(a_busy)
  );

  // len=320 instance and its FIFO model
  logic       b_fill, b_full, b_fifo_ready, b_fifo_clear, b_out_valid, b_out_ready, b_out_last, b_busy;
  logic [7:0] b_fifo_data, b_out_data;
  logic [8:0] b_read_ptr;
  logic [7:0] b_mem [320];

  assign b_fifo_ready = ~b_full;
  assign b_fifo_data  = (b_read_ptr < 9'd320) ? b_mem[b_read_ptr] : 8'h00;
  always @(posedge clk) begin
    if (rst || b_fifo_clear) b_full <= 1'b0;
    else if (b_fill)         b_full <= 1'b1;
  end

  blockfifo_reader u_b (
    .clk(clk), .reset(rst), .fifo_ready(b_fifo_ready), .fifo_data(b_fifo_data),
    .read_ptr(b_read_ptr), .fifo_clear(b_fifo_clear), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .out_last(b_out_last), .busy(b_busy)
  );

  // scoreboards: {last, data}
  logic [8:0] a_q[$];
  logic [8:0] b_q[$];
  int a_clr = 0, a_xfer = 0;
  int b_clr = 0, b_xfer = 0, b_lasts = 0;
  logic a_prev_last = 1'b0;
  logic b_prev_last = 1'b0;

  // inputs change at negedge; monitor looks 2 time units later at the values the next posedge will see
  initial forever begin
    @(negedge clk);
    #2;
    if (rst) begin
      a_prev_last = 1'b0;
      b_prev_last = 1'b0;
    end else begin
      if (a_fifo_clear) begin
        a_clr++;
        chk("a_clear_follows_last", 32'(a_prev_last), 1);
      end
      a_prev_last = 1'b0;
      if (a_out_valid && a_out_ready) begin
        a_xfer++;
        if (a_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL a_extra_word actual=%0h required=none", {a_out_last, a_out_data});
        end else begin
          chk("a_word", 32'({a_out_last, a_out_data}), 32'(a_q.pop_front()));
        end
        a_prev_last = a_out_last;
      end
      if (b_fifo_clear) begin
        b_clr++;
        chk("b_clear_follows_last", 32'(b_prev_last), 1);
      end
      b_prev_last = 1'b0;
      if (b_out_valid && b_out_ready) begin
        b_xfer++;
        if (b_out_last) b_lasts++;
        if (b_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL b_extra_word actual=%0h required=none", {b_out_last, b_out_data});
        end else begin
          chk("b_word", 32'({b_out_last, b_out_data}), 32'(b_q.pop_front()));
        end
        b_prev_last = b_out_last;
      end
    end
  end

  task automatic push_a_block(input int npass);
    for (int p = 0; p < npass; p++)
      for (int i = 0; i < 4; i++) a_q.push_back({(i == 3), a_mem[i]});
  endtask

  task automatic wait_a_clr(input int target);
    int n = 0;
    while (a_clr < target && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("a_clear_seen", a_clr, target);
  endtask

  task automatic find_a_word(input logic [7:0] w);
    int n = 0;
    while (!(a_out_valid && a_out_data == w) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("a_word_presented", a_out_data, 32'(w));
  endtask

  initial begin
    rst = 1'b1;
    a_fill = 1'b0; b_fill = 1'b0;
    a_out_ready = 1'b0; b_out_ready = 1'b0;
    a_mem[0] = 8'hAA; a_mem[1] = 8'hBB; a_mem[2] = 8'hCC; a_mem[3] = 8'hDD;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(a_out_valid), 0);
    chk("rst_ptr", 32'(a_read_ptr), 0);
    chk("rst_busy", 32'(a_busy), 0);
    chk("rst_clear", 32'(a_fifo_clear), 0);
    chk("rst_data", 32'(a_out_data), 0);
    chk("rst_last", 32'(a_out_last), 0);
    chk("rst_b_valid", 32'(b_out_valid), 0);
    rst = 1'b0;
    a_out_ready = 1'b1;

    // FIFO never full: reader must stay idle
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      chk("idle_valid", 32'(a_out_valid), 0);
      chk("idle_busy", 32'(a_busy), 0);
      chk("idle_ptr", 32'(a_read_ptr), 0);
    end

    // block 1, out_ready held high
    push_a_block(NPASS);
    a_fill = 1'b1;
    @(negedge clk);
    a_fill = 1'b0;
    @(negedge clk);
    chk("lat_load_valid", 32'(a_out_valid), 0);
    chk("lat_load_busy", 32'(a_busy), 1);
    @(negedge clk);
    chk("lat_first_valid", 32'(a_out_valid), 1);
    chk("lat_first_data", 32'(a_out_data), 32'h AA);
    chk("lat_first_ptr", 32'(a_read_ptr), 1);
    wait_a_clr(1);
    chk("blk1_busy_after", 32'(a_busy), 0);
    chk("blk1_fifo_ready", 32'(a_fifo_ready), 1);
    chk("blk1_xfers", a_xfer, 4 * NPASS);
    chk("blk1_q_empty", a_q.size(), 0);

    // block 2, stall 3 cycles on BB
    push_a_block(NPASS);
    a_fill = 1'b1;
    @(negedge clk);
    a_fill = 1'b0;
    find_a_word(8'hBB);
    a_out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stall_data", 32'(a_out_data), 32'h BB);
      chk("stall_valid", 32'(a_out_valid), 1);
      chk("stall_ptr", 32'(a_read_ptr), 2);
    end
    a_out_ready = 1'b1;
    wait_a_clr(2);
    chk("blk2_xfers", a_xfer, 8 * NPASS);
    chk("blk2_q_empty", a_q.size(), 0);

    // block 3, reset while CC is presented
    a_q.push_back({1'b0, 8'hAA});
    a_q.push_back({1'b0, 8'hBB});
    a_fill = 1'b1;
    @(negedge clk);
    a_fill = 1'b0;
    find_a_word(8'hCC);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_valid", 32'(a_out_valid), 0);
    chk("midrst_ptr", 32'(a_read_ptr), 0);
    chk("midrst_busy", 32'(a_busy), 0);
    chk("midrst_clear", 32'(a_fifo_clear), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrst_no_clear", a_clr, 2);
    chk("midrst_q_empty", a_q.size(), 0);
    chk("midrst_idle", 32'(a_busy), 0);

    // full-size blocks with random backpressure
    for (int blk = 0; blk < 2; blk++) begin
      int n = 0;
      for (int i = 0; i < 320; i++) b_mem[i] = 8'((i * 7 + blk * 53) & 255);
      for (int p = 0; p < NPASS; p++)
        for (int i = 0; i < 320; i++) b_q.push_back({(i == 319), b_mem[i]});
      b_fill = 1'b1;
      @(negedge clk);
      b_fill = 1'b0;
      while (b_clr < blk + 1 && n < 6000) begin
        b_out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        n++;
      end
      chk("b_clear_seen", b_clr, blk + 1);
      chk("b_xfers", b_xfer, 320 * NPASS * (blk + 1));
      chk("b_lasts", b_lasts, NPASS * (blk + 1));
      chk("b_q_empty", b_q.size(), 0);
      chk("b_idle", 32'(b_busy), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
